// File: rtl/demo_dose_sequencer.sv
// demo_dose_sequencer: timed dosing controller for the three-inlet mixing chip.
// It runs PRIME (soln3 only), a settle gap, MIX (all inlets), a settle gap, and
// then COLLECT (all inlets plus the outlet valve).
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start, abort      run request (used only in IDLE) and immediate stop (any state)
//   t_prime/t_mix/t_collect  phase durations in cycles, latched on start
//   pump_en[2:0]      inlet pumps: [0]=soln1, [1]=soln2, [2]=soln3
//   collect_en        outlet collection valve
//   busy, done, aborted  run status; done and aborted are one-cycle pulses
//   phase[2:0]        current state code, for debug
module demo_dose_sequencer #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned SETTLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] t_prime,
  input  logic [CNT_W-1:0] t_mix,
  input  logic [CNT_W-1:0] t_collect,
  output logic [2:0]       pump_en,
  output logic             collect_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [2:0]       phase
);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPrime   = 3'd1,
    StGapA    = 3'd2,
    StMix     = 3'd3,
    StGapB    = 3'd4,
    StCollect = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] SettleM1 = CNT_W'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] mix_q, mix_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [2:0]       pump_d;
  logic             col_en_d, busy_d, done_d, aborted_d;

  // Next state. The counter holds the cycles remaining in the current state
  // minus one; a state exits on the cycle it reads 0. Zero-length timed
  // states are skipped by choosing the following state directly.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mix_d     = mix_q;
    col_d     = col_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    if (state_q == StIdle) begin
      if (start && !abort) begin
        mix_d = t_mix;
        col_d = t_collect;
        if (t_prime != '0) begin
          state_d = StPrime;
          cnt_d   = t_prime - 1'b1;
        end else begin
          state_d = StGapA;
          cnt_d   = SettleM1;
        end
      end
    end else if (abort) begin
      state_d   = StIdle;
      cnt_d     = '0;
      aborted_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      case (state_q)
        StPrime: begin
          state_d = StGapA;
          cnt_d   = SettleM1;
        end
        StGapA: begin
          if (mix_q != '0) begin
            state_d = StMix;
            cnt_d   = mix_q - 1'b1;
          end else begin
            state_d = StGapB;
            cnt_d   = SettleM1;
          end
        end
        StMix: begin
          state_d = StGapB;
          cnt_d   = SettleM1;
        end
        StGapB: begin
          if (col_q != '0) begin
            state_d = StCollect;
            cnt_d   = col_q - 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          done_d  = (state_q == StCollect);
        end
      endcase
    end
  end

  // Output decode from the next state so every output is a flop.
  always_comb begin
    pump_d   = 3'b000;
    col_en_d = 1'b0;
    busy_d   = (state_d != StIdle);
    case (state_d)
      StPrime:   pump_d = 3'b100;
      StMix:     pump_d = 3'b111;
      StCollect: begin
        pump_d   = 3'b111;
        col_en_d = 1'b1;
      end
      default:   pump_d = 3'b000;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      mix_q      <= '0;
      col_q      <= '0;
      pump_en    <= 3'b000;
      collect_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mix_q      <= mix_d;
      col_q      <= col_d;
      pump_en    <= pump_d;
      collect_en <= col_en_d;
      busy       <= busy_d;
      done       <= done_d;
      aborted    <= aborted_d;
    end
  end

  assign phase = state_q;

endmodule

// File: tb/tb_demo_dose_sequencer.sv
// Self-checking bench for demo_dose_sequencer: a cycle-list reference model
// compared every cycle, directed scenarios with hand-computed counts, and a
// randomized soak.
module tb_demo_dose_sequencer;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned SETTLE = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] t_prime = '0;
  logic [CNT_W-1:0] t_mix = '0;
  logic [CNT_W-1:0] t_collect = '0;
  logic [2:0]       pump_en;
  logic             collect_en, busy, done, aborted;
  logic [2:0]       phase;

  int tests = 0;
  int fails = 0;

  demo_dose_sequencer #(.CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .t_prime(t_prime), .t_mix(t_mix), .t_collect(t_collect),
    .pump_en(pump_en), .collect_en(collect_en), .busy(busy),
    .done(done), .aborted(aborted), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a list of per-cycle expected outputs built
  // from the protocol, followed by one done cycle.
  typedef struct packed {
    logic [2:0] pump;
    logic       col;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [2:0] phase;
  } exp_t;

  exp_t q[$];
  exp_t cur = '0;

  function automatic exp_t mk(input logic [2:0] ph, input logic [2:0] p, input logic c);
    exp_t e;
    e = '0;
    e.phase = ph;
    e.pump  = p;
    e.col   = c;
    e.busy  = 1'b1;
    return e;
  endfunction

  task automatic build(input int tp, input int tm, input int tc);
    exp_t e;
    for (int i = 0; i < tp; i++) q.push_back(mk(3'd1, 3'b100, 1'b0));
    for (int i = 0; i < int'(SETTLE); i++) q.push_back(mk(3'd2, 3'b000, 1'b0));
    for (int i = 0; i < tm; i++) q.push_back(mk(3'd3, 3'b111, 1'b0));
    for (int i = 0; i < int'(SETTLE); i++) q.push_back(mk(3'd4, 3'b000, 1'b0));
    for (int i = 0; i < tc; i++) q.push_back(mk(3'd5, 3'b111, 1'b1));
    e = '0;
    e.done = 1'b1;
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      cur = '0;
    end else if (cur.busy && abort) begin
      q.delete();
      cur = '0;
      cur.aborted = 1'b1;
    end else begin
      if (!cur.busy && start && !abort) build(int'(t_prime), int'(t_mix), int'(t_collect));
      if (q.size() > 0) cur = q.pop_front();
      else cur = '0;
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    chk("pump_en", int'(pump_en), int'(cur.pump));
    chk("collect_en", int'(collect_en), int'(cur.col));
    chk("busy", int'(busy), int'(cur.busy));
    chk("done", int'(done), int'(cur.done));
    chk("aborted", int'(aborted), int'(cur.aborted));
    chk("phase", int'(phase), int'(cur.phase));
  end

  task automatic set_t(input int tp, input int tm, input int tc);
    t_prime   = CNT_W'(tp);
    t_mix     = CNT_W'(tm);
    t_collect = CNT_W'(tc);
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the first run cycle.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Observes from the current negedge until done/aborted, bounded.
  // restart_ph >= 0 re-asserts start whenever that phase is seen.
  task automatic observe(input int restart_ph, output int busy_n, output int prime_n,
                         output int mix_n, output int col_n, output int mask,
                         output bit got_done);
    busy_n = 0; prime_n = 0; mix_n = 0; col_n = 0; mask = 0; got_done = 0;
    for (int i = 0; i < 1000; i++) begin
      if (busy) begin
        busy_n++;
        mask |= (1 << phase);
        if (pump_en == 3'b100) prime_n++;
        if (pump_en == 3'b111 && !collect_en) mix_n++;
        if (collect_en) col_n++;
      end
      if (done) begin
        got_done = 1;
        break;
      end
      start = (restart_ph >= 0 && busy && int'(phase) == restart_ph);
      @(negedge clk);
    end
    start = 1'b0;
    if (!got_done) chk("run_timeout", 0, 1);
  endtask

  task automatic wait_phase(input int ph);
    int i;
    for (i = 0; i < 1000 && int'(phase) != ph; i++) @(negedge clk);
    if (int'(phase) != ph) chk("wait_phase_timeout", int'(phase), ph);
  endtask

  int bn, pn, mn, cn, mask, cnt;
  bit gd;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_phase", int'(phase), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nominal run
    set_t(10, 6, 3);
    pulse_start();
    observe(-1, bn, pn, mn, cn, mask, gd);
    chk("nom_busy_len", bn, 27);
    chk("nom_prime_len", pn, 10);
    chk("nom_mix_len", mn, 6);
    chk("nom_collect_len", cn, 3);
    chk("nom_done", int'(gd), 1);
    chk("nom_done_phase", int'(phase), 0);
    @(negedge clk);

    // Zero durations
    set_t(0, 5, 0);
    pulse_start();
    observe(-1, bn, pn, mn, cn, mask, gd);
    chk("zero_busy_len", bn, 13);
    chk("zero_mix_len", mn, 5);
    chk("zero_collect_len", cn, 0);
    chk("zero_phases", mask, 28);
    @(negedge clk);

    // Abort on the 3rd MIX cycle
    set_t(10, 6, 3);
    pulse_start();
    wait_phase(3);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_phase", int'(phase), 0);
    chk("abort_pump", int'(pump_en), 0);
    chk("abort_pulse", int'(aborted), 1);
    chk("abort_no_done", int'(done), 0);
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      cnt += int'(done) + int'(aborted) + int'(busy);
    end
    chk("abort_quiet_after", cnt, 0);

    // start while busy, inputs changed mid-run
    set_t(10, 6, 3);
    pulse_start();
    set_t(1, 1, 1);
    observe(4, bn, pn, mn, cn, mask, gd);
    chk("restart_busy_len", bn, 27);
    chk("restart_mix_len", mn, 6);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(busy);
    end
    chk("restart_no_second_run", cnt, 0);

    // Back-to-back: start on the done cycle
    set_t(10, 6, 3);
    pulse_start();
    observe(-1, bn, pn, mn, cn, mask, gd);
    chk("b2b_done_cycle_idle", int'(busy), 0);
    pulse_start();
    chk("b2b_second_busy", int'(busy), 1);
    chk("b2b_second_phase", int'(phase), 1);
    observe(-1, bn, pn, mn, cn, mask, gd);
    chk("b2b_second_len", bn, 27);
    @(negedge clk);

    // start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("collide_busy", int'(busy), 0);
    chk("collide_aborted", int'(aborted), 0);
    @(negedge clk);
    chk("collide_busy_later", int'(busy), 0);

    // Async reset mid-COLLECT
    set_t(10, 6, 3);
    pulse_start();
    wait_phase(5);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pump", int'(pump_en), 0);
    chk("rst_collect", int'(collect_en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_phase", int'(phase), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(busy);
    end
    chk("rst_stays_idle", cnt, 0);

    // Randomized soak against the model
    for (int i = 0; i < 4000; i++) begin
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 7) == 0)
        set_t($urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 12));
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
